// File: rtl/mul_iter_pkg.sv
// Shared types and helpers for the iterative MULT/MULTU unit.
package mul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Cycles from the accept edge to the edge that raises done:
    // one CALC edge per STEP-bit group plus the sign-fix edge.
    function automatic int unsigned op_cycles(input int unsigned width,
                                              input int unsigned step);
        return width / step + 1;
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One shift-add step: adds mag_a times the next STEP multiplier bits onto
// the upper half of the running product. The result is WIDTH+STEP bits wide
// so the carry out of the upper half is never lost.
module mul_iter_step
    import mul_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]      acc_hi,
    input  logic [WIDTH-1:0]      mag_a,
    input  logic [STEP-1:0]       b_bits,
    output logic [WIDTH+STEP-1:0] acc_next
);

    // Partial product is built from STEP shifted copies of the multiplicand.
    always_comb begin
        acc_next = {{STEP{1'b0}}, acc_hi};
        for (int i = 0; i < STEP; i++) begin
            if (b_bits[i]) begin
                acc_next = acc_next + ({{STEP{1'b0}}, mag_a} << i);
            end
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Multi-cycle integer multiplier for the MIPS HI/LO path.
// Operands are converted to sign-magnitude on accept, the magnitudes are
// multiplied STEP bits per cycle with a shift-add loop, and a final cycle
// restores the sign of the full 2*WIDTH product.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int NSTEPS = int'(op_cycles(WIDTH, STEP)) - 1;
    localparam int CNT_W  = $clog2(NSTEPS) + 1;
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(NSTEPS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

    state_t state;
    state_t state_nxt;

    logic                 sign_q;
    logic [WIDTH-1:0]     mag_a_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH+STEP-1:0] acc_next;
    logic [2*WIDTH-1:0]   prod_shifted;

    assign a_neg = (is_signed == MODE_SIGNED) && a[WIDTH-1];
    assign b_neg = (is_signed == MODE_SIGNED) && b[WIDTH-1];

    // The low half of prod_q starts as the multiplier magnitude; its bottom
    // STEP bits are the ones being retired this cycle.
    mul_iter_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc_hi   (prod_q[2*WIDTH-1:WIDTH]),
        .mag_a    (mag_a_q),
        .b_bits   (prod_q[STEP-1:0]),
        .acc_next (acc_next)
    );

    assign prod_shifted = {acc_next, prod_q[WIDTH-1:STEP]};

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = start ? CALC : IDLE;
            end
            CALC: begin
                busy      = 1'b1;
                state_nxt = (cnt_q == '0) ? SIGN : CALC;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iteration, sign fix and result hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sign_q  <= 1'b0;
            mag_a_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            z       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= a_neg ^ b_neg;
                        mag_a_q <= a_neg ? -a : a;
                        prod_q  <= {{WIDTH{1'b0}}, (b_neg ? -b : b)};
                        cnt_q   <= CNT_INIT;
                    end
                end
                CALC: begin
                    prod_q <= prod_shifted;
                    cnt_q  <= cnt_q - CNT_ONE;
                end
                SIGN: begin
                    z    <= sign_q ? ((~prod_q) + PROD_ONE) : prod_q;
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: three instances (STEP = 1, 2, 4) share one stimulus
// stream. A transaction-level model predicts busy/done/z for each instance
// every cycle, and literal results/latencies pin the model.
module tb_mul_iter;

    localparam int W  = 32;
    localparam int ND = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busy_o [ND];
    logic         done_o [ND];
    logic [2*W-1:0] z_o  [ND];

    mul_iter #(.WIDTH(W), .STEP(1)) dut_s1 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy_o[0]), .done(done_o[0]), .z(z_o[0])
    );
    mul_iter #(.WIDTH(W), .STEP(2)) dut_s2 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy_o[1]), .done(done_o[1]), .z(z_o[1])
    );
    mul_iter #(.WIDTH(W), .STEP(4)) dut_s4 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy_o[2]), .done(done_o[2]), .z(z_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Literal expectations published by the stimulus process.
    logic [2*W-1:0] lit_z   [ND];
    int             lit_lat [ND];
    int             lit_gap [ND];
    bit             lit_en  [ND];
    int             lit_id;
    bit             end_req;

    // Model state, one slot per instance.
    int unsigned    m_left [ND];
    logic [2*W-1:0] m_pend [ND];
    logic [2*W-1:0] m_z    [ND];
    logic           m_done [ND];
    bit             model_live;

    int total;
    int bad;

    function automatic int step_of(input int i);
        return 1 << i;
    endfunction

    // Accept-to-done latency: one cycle per STEP-bit group plus the sign cycle.
    function automatic int op_lat(input int i);
        return W / step_of(i) + 1;
    endfunction

    // Reference product: extend to 2W bits by the operand mode and multiply.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic s);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    task automatic check_output(input string name, input int idx,
                                input logic [2*W-1:0] act,
                                input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step=%0d t=%0t: got %h expected %h",
                     name, step_of(idx), $time, act, exp);
        end
    endtask

    // Model: an instance is idle or counting down to its done edge.
    initial begin
        model_live = 1'b0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < ND; i++) begin
                if (!reset) begin
                    m_left[i] = 0;
                    m_z[i]    = '0;
                    m_pend[i] = '0;
                    m_done[i] = 1'b0;
                end else if (m_left[i] == 0) begin
                    m_done[i] = 1'b0;
                    if (start) begin
                        m_pend[i] = ref_mul(a, b, is_signed);
                        m_left[i] = op_lat(i);
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                    m_done[i] = (m_left[i] == 0);
                    if (m_left[i] == 0) m_z[i] = m_pend[i];
                end
            end
            if (!reset) model_live = 1'b1;
        end
    end

    // Compare process: model checks every cycle, literal checks on done.
    initial begin
        int             cyc;
        int             seen_id;
        logic           prev_busy [ND];
        int             acc_cyc   [ND];
        int             last_done [ND];
        logic [2*W-1:0] exp_z     [ND];
        int             exp_lat   [ND];
        int             exp_gap   [ND];
        bit             pend      [ND];
        total   = 0;
        bad     = 0;
        cyc     = 0;
        seen_id = 0;
        for (int i = 0; i < ND; i++) begin
            prev_busy[i] = 1'b0;
            acc_cyc[i]   = 0;
            last_done[i] = 0;
            pend[i]      = 1'b0;
            exp_z[i]     = '0;
            exp_lat[i]   = 0;
            exp_gap[i]   = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (end_req) begin
                for (int i = 0; i < ND; i++)
                    check_output("result_pending_at_end", i, {63'b0, pend[i]}, '0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (lit_id != seen_id) begin
                for (int i = 0; i < ND; i++) begin
                    check_output("expected_done_missing", i, {63'b0, pend[i]}, '0);
                    pend[i]    = lit_en[i];
                    exp_z[i]   = lit_z[i];
                    exp_lat[i] = lit_lat[i];
                    exp_gap[i] = lit_gap[i];
                end
                seen_id = lit_id;
            end
            if (model_live) begin
                for (int i = 0; i < ND; i++) begin
                    check_output("busy", i, {63'b0, busy_o[i]}, {63'b0, (m_left[i] != 0)});
                    check_output("done", i, {63'b0, done_o[i]}, {63'b0, m_done[i]});
                    check_output("z", i, z_o[i], m_z[i]);
                    if (busy_o[i] === 1'b1 && prev_busy[i] !== 1'b1) acc_cyc[i] = cyc;
                    prev_busy[i] = busy_o[i];
                    if (done_o[i] === 1'b1) begin
                        if (pend[i]) begin
                            check_output("z_literal", i, z_o[i], exp_z[i]);
                            check_output("latency", i, 64'(cyc - acc_cyc[i]), 64'(exp_lat[i]));
                            if (exp_gap[i] != 0)
                                check_output("done_spacing", i, 64'(cyc - last_done[i]),
                                             64'(exp_gap[i]));
                            pend[i] = 1'b0;
                        end
                        last_done[i] = cyc;
                    end
                end
            end
        end
    end

    // One operation on all instances with literal result and latencies.
    task automatic apply_stimulus(input logic s, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [2*W-1:0] ez);
        for (int i = 0; i < ND; i++) begin
            lit_z[i]   = ez;
            lit_gap[i] = 0;
            lit_en[i]  = 1'b1;
        end
        lit_lat[0] = 33;
        lit_lat[1] = 17;
        lit_lat[2] = 9;
        lit_id++;
        is_signed = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~s;
        a         = ~x;
        b         = ~y;
        repeat (40) @(negedge clk);
    endtask

    // Stimulus sequence.
    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        lit_id    = 0;
        end_req   = 1'b0;
        for (int i = 0; i < ND; i++) begin
            lit_z[i]   = '0;
            lit_lat[i] = 0;
            lit_gap[i] = 0;
            lit_en[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        apply_stimulus(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        apply_stimulus(1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        apply_stimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        apply_stimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd0, 64'h0);

        // Start held high with changing operands; STEP=1 instance pinned.
        for (int i = 0; i < ND; i++) lit_en[i] = 1'b0;
        lit_en[0]  = 1'b1;
        lit_z[0]   = 64'd42;
        lit_lat[0] = 33;
        lit_gap[0] = 0;
        lit_id++;
        is_signed = 1'b0;
        a         = 32'd7;
        b         = 32'd6;
        start     = 1'b1;
        for (int j = 0; j < 33; j++) begin
            @(negedge clk);
            a = 32'd100 + 32'(j);
            b = 32'd3 + 32'(j);
        end
        @(negedge clk);
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start      = 1'b0;
        a          = '0;
        b          = '0;
        lit_z[0]   = 64'd81;
        lit_lat[0] = 33;
        lit_gap[0] = 34;
        lit_id++;
        repeat (45) @(negedge clk);

        // Reset ten cycles into an operation, then a normal run.
        is_signed = 1'b1;
        a         = 32'd3;
        b         = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(1'b0, 32'd2, 32'd2, 64'd4);

        end_req = 1'b1;
        repeat (5) @(negedge clk);
        $display("[TB] FAIL end_of_test: summary not reached, got 0 expected 1");
        $fatal(1, "[TB] bench did not terminate");
    end

endmodule
